// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts one byte over valid/ready and shifts it out as
// start bit, LSB-first data, optional parity and one or two stop bits.
module uart_tx_serializer #(
    parameter int DATA_BITS = 8,
    parameter int CFG_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CFG_W-1:0]     delitel,
    input  logic [CFG_W-1:0]     parity_bit_mode,
    input  logic [CFG_W-1:0]     stop_bit_num,
    input  logic                 s_tvalid,
    input  logic [DATA_BITS-1:0] s_tdata,
    output logic                 s_tready,
    output logic                 tx,
    output logic                 busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam int               CNT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);

    logic [2:0]           state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CFG_W-1:0]     div_cnt;
    logic [CFG_W-1:0]     period_m1;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_en_q;
    logic                 parity_q;
    logic                 stop_two_q;
    logic                 bit_done;
    logic                 cfg_unused;

    // Only the two low bits of the parity mode carry meaning.
    assign cfg_unused = ^parity_bit_mode[CFG_W-1:2];

    assign bit_done = (div_cnt == '0);

    // NOTE: every register here is sequential state, so it is assigned with <= only;
    // blocking assignments would make the result depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            tx          <= 1'b1;
            s_tready    <= 1'b1;
            busy        <= 1'b0;
            bit_cnt     <= '0;
            div_cnt     <= '0;
            period_m1   <= '0;
            shift_q     <= '0;
            parity_en_q <= 1'b0;
            parity_q    <= 1'b0;
            stop_two_q  <= 1'b0;
        end else begin
            // Bit-period down-counter, reloaded at every bit boundary.
            if (state != S_IDLE)
                div_cnt <= bit_done ? period_m1 : div_cnt - CFG_W'(1);

            case (state)
                S_IDLE: begin
                    if (s_tvalid) begin
                        state       <= S_START;
                        tx          <= 1'b0;
                        s_tready    <= 1'b0;
                        busy        <= 1'b1;
                        shift_q     <= s_tdata;
                        period_m1   <= (delitel == '0) ? '0 : delitel - CFG_W'(1);
                        div_cnt     <= (delitel == '0) ? '0 : delitel - CFG_W'(1);
                        parity_en_q <= (parity_bit_mode[1:0] == 2'd1) ||
                                       (parity_bit_mode[1:0] == 2'd2);
                        // Odd parity is the inverse of the data XOR.
                        parity_q    <= (^s_tdata) ^ (parity_bit_mode[1:0] == 2'd2);
                        stop_two_q  <= (stop_bit_num == CFG_W'(2));
                    end
                end

                S_START: begin
                    if (bit_done) begin
                        state   <= S_DATA;
                        tx      <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        bit_cnt <= '0;
                    end
                end

                S_DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (parity_en_q) begin
                                state <= S_PARITY;
                                tx    <= parity_q;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            tx      <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end

                S_PARITY: begin
                    if (bit_done) begin
                        state   <= S_STOP;
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                    end
                end

                S_STOP: begin
                    if (bit_done) begin
                        if (stop_two_q && bit_cnt == '0) begin
                            bit_cnt <= CNT_W'(1);
                        end else begin
                            state    <= S_IDLE;
                            s_tready <= 1'b1;
                            busy     <= 1'b0;
                            div_cnt  <= '0;
                            bit_cnt  <= '0;
                        end
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    tx       <= 1'b1;
                    s_tready <= 1'b1;
                    busy     <= 1'b0;
                    div_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: a frame-level model expands each accepted byte into
// the expected per-cycle line levels; a compare process checks every cycle.
module tb_uart_tx_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] delitel = 32'd4;
    logic [31:0] parity_bit_mode = 32'd0;
    logic [31:0] stop_bit_num = 32'd1;
    logic        s_tvalid = 1'b0;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tready;
    logic        tx;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    logic exp_q[$];
    logic last_frame[$];

    uart_tx_serializer #(.DATA_BITS(8), .CFG_W(32)) dut (
        .clk(clk), .rst(rst), .delitel(delitel), .parity_bit_mode(parity_bit_mode),
        .stop_bit_num(stop_bit_num), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
        .s_tready(s_tready), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line levels of one frame, one entry per clock cycle.
    function automatic void build_frame(input logic [7:0] d);
        int   per;
        logic bits[$];
        per = (delitel == 0) ? 1 : int'(delitel);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (parity_bit_mode[1:0] == 2'd1) bits.push_back(^d);
        if (parity_bit_mode[1:0] == 2'd2) bits.push_back(~^d);
        bits.push_back(1'b1);
        if (stop_bit_num == 2) bits.push_back(1'b1);
        last_frame.delete();
        foreach (bits[i])
            for (int k = 0; k < per; k++) last_frame.push_back(bits[i]);
        exp_q = last_frame;
    endfunction

    initial begin : model
        bit was_idle;
        forever begin
            @(posedge clk);
            was_idle = (exp_q.size() == 0);
            if (!was_idle) void'(exp_q.pop_front());
            if (rst) exp_q.delete();
            else if (was_idle && s_tvalid) build_frame(s_tdata);
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                if (exp_q.size() != 0) check("line {tx,busy,ready}", {29'd0, tx, busy, s_tready}, {29'd0, exp_q[0], 2'b10});
                else                   check("idle {tx,busy,ready}", {29'd0, tx, busy, s_tready}, 32'd5);
            end
        end
    end

    task automatic send(input logic [7:0] d, input int exp_len, input string name);
        int len;
        @(posedge clk); #1;
        s_tvalid = 1'b1;
        s_tdata  = d;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tdata  = ~d;
        check({name, " model len"}, last_frame.size(), exp_len);
        @(negedge clk);
        check({name, " tx falls"}, {31'd0, tx}, 32'd0);
        len = 0;
        while (busy && len < 5000) begin
            len++;
            @(negedge clk);
        end
        check({name, " busy len"}, len, exp_len);
        check({name, " ready back"}, {31'd0, s_tready}, 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset state", {29'd0, tx, busy, s_tready}, 32'd5);

        // 0x55, 4-cycle bits, no parity, one stop bit.
        send(8'h55, 40, "f55");
        check("f55 bit0 level", {31'd0, last_frame[4]}, 32'd1);
        check("f55 bit1 level", {31'd0, last_frame[8]}, 32'd0);

        // Even and odd parity on 0x07 with 2-cycle bits.
        delitel = 2; parity_bit_mode = 1;
        send(8'h07, 22, "even");
        check("even parity bit", {31'd0, last_frame[18]}, 32'd1);
        parity_bit_mode = 2;
        send(8'h07, 22, "odd");
        check("odd parity bit", {31'd0, last_frame[18]}, 32'd0);

        // Stop bit count.
        delitel = 3; parity_bit_mode = 0; stop_bit_num = 2;
        send(8'hA3, 33, "stop2");
        stop_bit_num = 5;
        send(8'hA3, 30, "stop5");

        // Divider 0 means one cycle per bit; upper parity bits ignored (mode 3 -> none).
        delitel = 0; stop_bit_num = 1; parity_bit_mode = 32'hFFFF_FFF7;
        send(8'hFF, 10, "div0");
        parity_bit_mode = 0;

        // Back-to-back frames with s_tvalid held high.
        @(posedge clk); #1;
        s_tvalid = 1'b1; s_tdata = 8'h00;
        @(posedge clk); #1;
        s_tdata = 8'hFF;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("gap idle tx", {31'd0, tx}, 32'd1);
        check("gap ready", {31'd0, s_tready}, 32'd1);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        @(negedge clk);
        check("second start", {31'd0, tx}, 32'd0);
        repeat (12) @(negedge clk);

        // Configuration change mid-frame only affects the next frame.
        delitel = 4; parity_bit_mode = 0;
        fork
            send(8'h55, 40, "cfg old");
            begin
                repeat (10) @(posedge clk);
                #1 delitel = 8; parity_bit_mode = 1;
            end
        join
        send(8'h55, 88, "cfg new");
        check("cfg new parity", {31'd0, last_frame[72]}, 32'd0);

        // Reset during data bit 3.
        delitel = 4; parity_bit_mode = 0;
        @(posedge clk); #1;
        s_tvalid = 1'b1; s_tdata = 8'h3C;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        repeat (17) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid reset state", {29'd0, tx, busy, s_tready}, 32'd5);
        send(8'h96, 40, "after rst");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit stage directly downstream of the APB register block. Consumes its `delitel`, `parity_bit_mode` and `stop_bit_num` outputs.
- Accepts bytes over a valid/ready stream and serializes them onto the UART TX line: start bit, data LSB first, optional parity, 1 or 2 stop bits.
- Bit timing comes from the programmed divider.
- One frame in flight; no internal FIFO.

Parameters:
- DATA_BITS, 8, data bits per frame; also the width of s_tdata.
- CFG_W, 32, width of the configuration inputs.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- delitel  input  CFG_W  clock cycles per bit period
- parity_bit_mode  input  CFG_W  [1:0]: 0 none, 1 even, 2 odd, 3 none; upper bits ignored
- stop_bit_num  input  CFG_W  2 = two stop bits; any other value = one stop bit
- s_tvalid  input  1  byte available
- s_tdata  input  DATA_BITS  byte to send
- s_tready  output  1  serializer can accept a byte
- tx  output  1  serial line, idles high
- busy  output  1  frame in progress

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); all state is updated only on posedge clk.
- Reset values:
  - tx=1, s_tready=1, busy=0.
  - State IDLE; bit counter and divider counter = 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - s_tready=1, tx=1, busy=0.
  - A handshake (s_tvalid && s_tready) in cycle N latches:
    - s_tdata;
    - period = (delitel==0) ? 1 : delitel;
    - parity mode = parity_bit_mode[1:0];
    - stop count = (stop_bit_num==2) ? 2 : 1.
  - The FSM then enters START at N+1.
- Outputs are registered:
  - tx goes low at cycle N+1.
  - s_tready drops to 0 at N+1.
  - busy goes to 1 at N+1.
- Bit timing: every bit is held on tx for exactly `period` cycles, using a down-counter reloaded at each bit boundary.
- START: tx=0 for one period, then go to DATA.
- DATA:
  - tx = data[i] for i = 0..DATA_BITS-1, LSB first.
  - After the last bit: go to PARITY if parity mode is 1 or 2, otherwise go to STOP.
- PARITY:
  - Even mode: tx = XOR of the data bits.
  - Odd mode: tx = inverted XOR of the data bits.
  - One period, then go to STOP.
- STOP: tx=1 for stop count × period cycles, then go to IDLE.
- Busy window: busy=1 for exactly (1 + DATA_BITS + P + S) × period cycles, where P ∈ {0,1} and S ∈ {1,2}.
- Frame spacing: the IDLE cycle after a frame always lasts at least one clock.
  - Back-to-back frames are therefore separated by one extra tx=1 cycle.
  - If s_tvalid is held high, the next handshake happens in that IDLE cycle.
- Configuration changes while busy=1 are ignored until the next handshake.
- s_tdata changes while busy=1 are ignored.
- s_tready is never 1 while busy=1. s_tvalid while not ready has no effect.
- Reset mid-frame: in the cycle after rst is sampled high, tx=1, state=IDLE, s_tready=1. The frame is abandoned, not completed.
- Divider arithmetic: the counter is CFG_W wide. delitel=0xFFFFFFFF is legal (very long bit period, no overflow).
- Data bits shift out of a shift register. The parity bit is computed from the latched byte at the handshake, not from the line.

Test Plan:
- delitel=4, parity=0, stop=1, send 0x55:
  - tx falls 1 cycle after the handshake;
  - line sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles;
  - busy high exactly 40 cycles;
  - s_tready returns to 1 on cycle 41.
- delitel=2, parity=1 (even), send 0x07 → parity bit 1. parity=2 (odd), send 0x07 → parity bit 0. busy = 22 cycles in both cases.
- delitel=3, stop_bit_num=2, parity=0, send 0xA3 → stop high for 6 cycles, busy = 33 cycles. Repeat with stop_bit_num=5 → one stop bit, busy = 30 cycles.
- delitel=0, send 0xFF → every bit lasts 1 cycle, busy = 10 cycles. Hold s_tvalid high with 0x00 then 0xFF → second start bit follows exactly 1 idle-high cycle after the first frame.
- Change delitel 4→8 and parity 0→1 in the middle of a 0x55 frame → current frame keeps 4-cycle bits and no parity; next frame uses 8-cycle bits plus parity.
- Assert rst for 1 cycle during DATA bit 3 → next cycle tx=1, busy=0, s_tready=1. A new byte sent afterwards frames correctly.
